hist_lut_bank_ctrl: RTL and testbench
=====================================

Name: hist_lut_bank_ctrl

Overview:
- Sequences histogram-equalization LUT updates: decides on which frames a rebuild runs, issues the start pulse, and steers the rebuilder's LUT writes into the inactive half of a ping-pong LUT RAM.
- Swaps the active bank only at a frame boundary, so the pixel mapper never reads a partially written LUT.
- Sits between hist_rebuilder's LUT write port and the dual-bank hist LUT RAM; rd_bank drives the mapper's bank address bit.

Parameters:
- ADDR_W, 14, LUT address width per bank (2^ADDR_W entries).
- DATA_W, 8, LUT entry width.
- UPD_PERIOD, 1, rebuild every UPD_PERIOD frames (>=1).
- TIMEOUT_CYC, 1048576, max cycles allowed in FILL before abort.

Ports:
- clk  in  1  clock.
- srst  in  1  reset: asynchronous, active-high.
- enable  in  1  level; 1 = scheduling active.
- sof  in  1  single-cycle start-of-frame pulse.
- rebuild_start  out  1  one-cycle pulse to the rebuilder.
- lut_we_in  in  1  rebuilder LUT write strobe.
- lut_addr_in  in  ADDR_W  rebuilder LUT address.
- lut_din_in  in  DATA_W  rebuilder LUT data.
- lut_ram_we  out  1  LUT RAM write enable.
- lut_ram_addr  out  ADDR_W+1  {bank, addr}; MSB is the write bank.
- lut_ram_din  out  DATA_W  LUT RAM write data.
- rd_bank  out  1  bank the mapper reads.
- bank_swap  out  1  one-cycle pulse when rd_bank toggles.
- busy  out  1  1 in FILL or PENDING.
- timeout_err  out  1  sticky; set on FILL timeout.
- fill_err  out  1  sticky; set on incomplete or stray fill.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All outputs are 0, state IDLE, frame_cnt=0, wr_cnt=0, wdog=0.
  - Reset mid-FILL discards the fill; rd_bank returns to 0.
- States:
  - IDLE: outputs idle. enable=1 -> WAIT_SOF with frame_cnt=0.
  - WAIT_SOF:
    - On sof, frame_cnt+1.
    - When the incremented value equals UPD_PERIOD: frame_cnt<=0, rebuild_start=1 in the next cycle, go to FILL, clear wr_cnt and wdog.
  - FILL:
    - Each lut_we_in is forwarded registered, 1-cycle latency: lut_ram_we<=1, lut_ram_addr<={~rd_bank, lut_addr_in}, lut_ram_din<=lut_din_in. wr_cnt+1 per write.
    - Write with lut_addr_in = all-ones:
      - If wr_cnt (pre-increment) = 2^ADDR_W-1 -> PENDING.
      - Otherwise set fill_err and go to WAIT_SOF; no swap.
    - sof in FILL is ignored and does not advance frame_cnt.
    - wdog increments every FILL cycle. Reaching TIMEOUT_CYC sets timeout_err and goes to WAIT_SOF; no swap, rd_bank unchanged.
  - PENDING:
    - On sof: rd_bank toggles in the next cycle, bank_swap=1 for that cycle, go to WAIT_SOF with frame_cnt=1 (this sof counts as frame 1).
    - With UPD_PERIOD=1 the same sof also triggers the next rebuild: rebuild_start fires in the same cycle as bank_swap, and the next fill targets the new inactive bank.
- Write steering:
  - lut_we_in outside FILL is dropped (lut_ram_we stays 0) and sets fill_err.
  - The inactive bank is computed from the current rd_bank, never from a pending toggle.
- enable deassert:
  - From any state other than IDLE -> IDLE on the next cycle.
  - A fill in progress is abandoned, rd_bank is held, and no rebuild_start is issued.
  - In-flight registered writes still complete that cycle.
- Simultaneous events:
  - sof and lut_we_in at the last address in the same FILL cycle: go to PENDING; that sof does not swap. Swap waits for the next sof.
  - sof on the same cycle enable rises: ignored. Counting starts in WAIT_SOF.
- Counter widths:
  - wr_cnt: ADDR_W+1 bits.
  - frame_cnt: clog2(UPD_PERIOD+1) bits.
  - wdog: clog2(TIMEOUT_CYC+1) bits, saturating.
- Error flags: timeout_err and fill_err clear only on srst.
- busy = (state==FILL) | (state==PENDING).

Test Plan:
All tests use ADDR_W=4, UPD_PERIOD=2, TIMEOUT_CYC=64.
- Reset, enable=1, two sof pulses -> rebuild_start pulse the cycle after the 2nd sof. Write addr 0..15 in order -> lut_ram_addr = 16..31 (bank 1), busy=1. Next sof -> bank_swap pulse, rd_bank=1.
- After the first swap, run the next cycle -> fill targets addresses 0..15, and rd_bank returns to 0 at the following sof.
- In FILL, write only addr 0..9 then stall -> at wdog=64: timeout_err=1, state WAIT_SOF, rd_bank unchanged, no bank_swap.
- In FILL, write addr 0..7 then addr 15 -> fill_err=1, no PENDING, no swap. Stray lut_we_in in WAIT_SOF -> lut_ram_we stays 0, fill_err=1.
- Drive sof in the same cycle as the addr-15 write -> state PENDING, no swap. Swap occurs only at the following sof.
- enable=0 mid-FILL, then srst mid-PENDING with rd_bank=1 -> IDLE, no rebuild_start. After reset: rd_bank=0, all outputs 0, error flags 0.

Source files
------------

// File: rtl/hist_lut_bank_ctrl.sv
// Ping-pong LUT bank controller for histogram equalization: schedules rebuilds,
// steers rebuilder writes into the inactive bank and swaps banks on frame starts.
module hist_lut_bank_ctrl #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8,
  parameter int UPD_PERIOD  = 1,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable,
  input  logic              sof,
  output logic              rebuild_start,
  input  logic              lut_we_in,
  input  logic [ADDR_W-1:0] lut_addr_in,
  input  logic [DATA_W-1:0] lut_din_in,
  output logic              lut_ram_we,
  output logic [ADDR_W:0]   lut_ram_addr,
  output logic [DATA_W-1:0] lut_ram_din,
  output logic              rd_bank,
  output logic              bank_swap,
  output logic              busy,
  output logic              timeout_err,
  output logic              fill_err
);

  localparam int FC_W = $clog2(UPD_PERIOD + 1);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_SOF = 2'd1;
  localparam logic [1:0] S_FILL     = 2'd2;
  localparam logic [1:0] S_PENDING  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   LAST_CNT  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   WR_ONE    = (ADDR_W+1)'(1);
  localparam logic [FC_W-1:0]   PERIOD    = FC_W'(UPD_PERIOD);
  localparam logic [FC_W-1:0]   FC_ONE    = FC_W'(1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);

  logic [1:0]        state_reg, state_next;
  logic [FC_W-1:0]   frame_cnt_reg, frame_cnt_next, frame_inc;
  logic [ADDR_W:0]   wr_cnt_reg, wr_cnt_next;
  logic [WD_W-1:0]   wdog_reg, wdog_next;
  logic              rd_bank_reg, rd_bank_next;
  logic              start_reg, start_next;
  logic              swap_reg, swap_next;
  logic              timeout_err_reg, timeout_err_next;
  logic              fill_err_reg, fill_err_next;
  logic              we_reg, we_next;
  logic [ADDR_W:0]   addr_reg, addr_next;
  logic [DATA_W-1:0] din_reg, din_next;

  always_comb begin
    state_next       = state_reg;
    frame_cnt_next   = frame_cnt_reg;
    wr_cnt_next      = wr_cnt_reg;
    wdog_next        = wdog_reg;
    rd_bank_next     = rd_bank_reg;
    start_next       = 1'b0;
    swap_next        = 1'b0;
    timeout_err_next = timeout_err_reg;
    fill_err_next    = fill_err_reg;
    we_next          = 1'b0;
    addr_next        = addr_reg;
    din_next         = din_reg;
    frame_inc        = frame_cnt_reg + FC_ONE;

    // Target bank always derives from the registered rd_bank, never a pending toggle.
    if (state_reg == S_FILL && lut_we_in) begin
      we_next   = 1'b1;
      addr_next = {~rd_bank_reg, lut_addr_in};
      din_next  = lut_din_in;
    end else if (lut_we_in) begin
      fill_err_next = 1'b1;
    end

    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next     = S_WAIT_SOF;
          frame_cnt_next = '0;
        end
        S_WAIT_SOF: begin
          if (sof) begin
            if (frame_inc == PERIOD) begin
              frame_cnt_next = '0;
              start_next     = 1'b1;
              state_next     = S_FILL;
              wr_cnt_next    = '0;
              wdog_next      = '0;
            end else begin
              frame_cnt_next = frame_inc;
            end
          end
        end
        S_FILL: begin
          if (wdog_reg != WD_LIMIT)
            wdog_next = wdog_reg + WD_ONE;
          if (lut_we_in)
            wr_cnt_next = wr_cnt_reg + WR_ONE;
          // A last-address write decides the fill outcome before the watchdog does.
          if (lut_we_in && lut_addr_in == LAST_ADDR) begin
            if (wr_cnt_reg == LAST_CNT) begin
              state_next = S_PENDING;
            end else begin
              fill_err_next = 1'b1;
              state_next    = S_WAIT_SOF;
            end
          end else if (wdog_reg >= WD_LAST) begin
            timeout_err_next = 1'b1;
            state_next       = S_WAIT_SOF;
          end
        end
        default: begin
          if (sof) begin
            swap_next    = 1'b1;
            rd_bank_next = ~rd_bank_reg;
            // The swapping sof is frame 1 of the next period.
            if (PERIOD == FC_ONE) begin
              start_next     = 1'b1;
              state_next     = S_FILL;
              frame_cnt_next = '0;
              wr_cnt_next    = '0;
              wdog_next      = '0;
            end else begin
              state_next     = S_WAIT_SOF;
              frame_cnt_next = FC_ONE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_reg       <= S_IDLE;
      frame_cnt_reg   <= '0;
      wr_cnt_reg      <= '0;
      wdog_reg        <= '0;
      rd_bank_reg     <= 1'b0;
      start_reg       <= 1'b0;
      swap_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      fill_err_reg    <= 1'b0;
      we_reg          <= 1'b0;
      addr_reg        <= '0;
      din_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      frame_cnt_reg   <= frame_cnt_next;
      wr_cnt_reg      <= wr_cnt_next;
      wdog_reg        <= wdog_next;
      rd_bank_reg     <= rd_bank_next;
      start_reg       <= start_next;
      swap_reg        <= swap_next;
      timeout_err_reg <= timeout_err_next;
      fill_err_reg    <= fill_err_next;
      we_reg          <= we_next;
      addr_reg        <= addr_next;
      din_reg         <= din_next;
    end
  end

  assign rebuild_start = start_reg;
  assign lut_ram_we    = we_reg;
  assign lut_ram_addr  = addr_reg;
  assign lut_ram_din   = din_reg;
  assign rd_bank       = rd_bank_reg;
  assign bank_swap     = swap_reg;
  assign busy          = (state_reg == S_FILL) | (state_reg == S_PENDING);
  assign timeout_err   = timeout_err_reg;
  assign fill_err      = fill_err_reg;

endmodule

// File: tb/tb_hist_lut_bank_ctrl.sv
// Directed bench for hist_lut_bank_ctrl with ADDR_W=4, UPD_PERIOD=2, TIMEOUT_CYC=64.
module tb_hist_lut_bank_ctrl;

  logic       clk = 1'b0;
  logic       srst, enable, sof, lut_we_in;
  logic [3:0] lut_addr_in;
  logic [7:0] lut_din_in;
  logic       rebuild_start, lut_ram_we, rd_bank, bank_swap, busy, timeout_err, fill_err;
  logic [4:0] lut_ram_addr;
  logic [7:0] lut_ram_din;

  int n_checks = 0;
  int n_fail   = 0;

  hist_lut_bank_ctrl #(
    .ADDR_W(4), .DATA_W(8), .UPD_PERIOD(2), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .srst(srst), .enable(enable), .sof(sof),
    .rebuild_start(rebuild_start),
    .lut_we_in(lut_we_in), .lut_addr_in(lut_addr_in), .lut_din_in(lut_din_in),
    .lut_ram_we(lut_ram_we), .lut_ram_addr(lut_ram_addr), .lut_ram_din(lut_ram_din),
    .rd_bank(rd_bank), .bank_swap(bank_swap), .busy(busy),
    .timeout_err(timeout_err), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    lut_we_in   = 1'b1;
    lut_addr_in = a;
    lut_din_in  = d;
    tick();
    lut_we_in   = 1'b0;
  endtask

  // Writes a..b in order and checks each forwarded write lands in bank wbank.
  task automatic fill_range(input int lo, input int hi, input logic wbank, input string tag);
    logic [3:0] a;
    logic [7:0] d;
    logic [4:0] exp_addr;
    for (int i = lo; i <= hi; i++) begin
      a = 4'(i);
      d = 8'(i * 3 + 1);
      exp_addr = {wbank, a};
      do_write(a, d);
      $display("write %s addr=%0d din=%0h -> ram_we=%0b ram_addr=%0d ram_din=%0h",
               tag, a, d, lut_ram_we, lut_ram_addr, lut_ram_din);
      n_checks++;
      if (lut_ram_we !== 1'b1 || lut_ram_addr !== exp_addr || lut_ram_din !== d) begin
        n_fail++;
        $display("FAIL %s_write%0d: we=%0b addr=%0d din=%0h required we=1 addr=%0d din=%0h",
                 tag, i, lut_ram_we, lut_ram_addr, lut_ram_din, exp_addr, d);
      end
    end
  endtask

  task automatic test_reset();
    srst = 1'b1; enable = 1'b0; sof = 1'b0; lut_we_in = 1'b0;
    lut_addr_in = '0; lut_din_in = '0;
    tick(); tick();
    srst = 1'b0;
    tick();
    $display("reset: outputs start=%0b we=%0b rd_bank=%0b swap=%0b busy=%0b terr=%0b ferr=%0b",
             rebuild_start, lut_ram_we, rd_bank, bank_swap, busy, timeout_err, fill_err);
    n_checks++;
    if ({rebuild_start, lut_ram_we, rd_bank, bank_swap, busy, timeout_err, fill_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0000000",
               {rebuild_start, lut_ram_we, rd_bank, bank_swap, busy, timeout_err, fill_err});
    end
    n_checks++;
    if (lut_ram_addr !== 5'd0 || lut_ram_din !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr=%0d din=%0h required 0 0", lut_ram_addr, lut_ram_din);
    end
  endtask

  task automatic test_first_rebuild();
    enable = 1'b1;
    pulse_sof();  // coincides with enable rising: must not count
    pulse_sof();  // frame 1
    $display("sof frame1: start=%0b busy=%0b", rebuild_start, busy);
    n_checks++;
    if (rebuild_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL first_frame1: start=%0b busy=%0b required 0 0", rebuild_start, busy);
    end
    tick();
    pulse_sof();  // frame 2 -> rebuild
    $display("sof frame2: start=%0b busy=%0b", rebuild_start, busy);
    n_checks++;
    if (rebuild_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start: start=%0b busy=%0b required 1 1", rebuild_start, busy);
    end
    tick();
    n_checks++;
    if (rebuild_start !== 1'b0) begin
      n_fail++;
      $display("FAIL first_start_width: start=%0b required 0", rebuild_start);
    end
    fill_range(0, 15, 1'b1, "first");
    tick();
    n_checks++;
    if (lut_ram_we !== 1'b0 || busy !== 1'b1 || bank_swap !== 1'b0 || rd_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL first_pending: we=%0b busy=%0b swap=%0b rd_bank=%0b required 0 1 0 0",
               lut_ram_we, busy, bank_swap, rd_bank);
    end
    pulse_sof();
    $display("sof swap: swap=%0b rd_bank=%0b busy=%0b", bank_swap, rd_bank, busy);
    n_checks++;
    if (bank_swap !== 1'b1 || rd_bank !== 1'b1 || busy !== 1'b0 || rebuild_start !== 1'b0) begin
      n_fail++;
      $display("FAIL first_swap: swap=%0b rd_bank=%0b busy=%0b start=%0b required 1 1 0 0",
               bank_swap, rd_bank, busy, rebuild_start);
    end
    tick();
    n_checks++;
    if (bank_swap !== 1'b0 || rd_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL first_swap_width: swap=%0b rd_bank=%0b required 0 1", bank_swap, rd_bank);
    end
  endtask

  task automatic test_second_rebuild();
    pulse_sof();  // swap sof counted as frame 1, so this is frame 2
    $display("sof second: start=%0b", rebuild_start);
    n_checks++;
    if (rebuild_start !== 1'b1) begin
      n_fail++;
      $display("FAIL second_start: start=%0b required 1", rebuild_start);
    end
    fill_range(0, 15, 1'b0, "second");
    tick();
    pulse_sof();
    $display("sof swap2: swap=%0b rd_bank=%0b", bank_swap, rd_bank);
    n_checks++;
    if (bank_swap !== 1'b1 || rd_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL second_swap: swap=%0b rd_bank=%0b required 1 0", bank_swap, rd_bank);
    end
    tick();
  endtask

  task automatic test_timeout();
    pulse_sof();
    n_checks++;
    if (rebuild_start !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_start: start=%0b required 1", rebuild_start);
    end
    fill_range(0, 9, 1'b1, "timeout");
    repeat (53) tick();  // 63 FILL cycles elapsed
    $display("fill cycle 63: busy=%0b terr=%0b", busy, timeout_err);
    n_checks++;
    if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: busy=%0b terr=%0b required 1 0", busy, timeout_err);
    end
    tick();
    $display("fill cycle 64: busy=%0b terr=%0b rd_bank=%0b swap=%0b",
             busy, timeout_err, rd_bank, bank_swap);
    n_checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || rd_bank !== 1'b0 || bank_swap !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_hit: busy=%0b terr=%0b rd_bank=%0b swap=%0b required 0 1 0 0",
               busy, timeout_err, rd_bank, bank_swap);
    end
    pulse_sof();
    n_checks++;
    if (bank_swap !== 1'b0 || rd_bank !== 1'b0 || rebuild_start !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_noswap: swap=%0b rd_bank=%0b start=%0b required 0 0 0",
               bank_swap, rd_bank, rebuild_start);
    end
  endtask

  task automatic test_stray_write();
    n_checks++;
    if (fill_err !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_pre: ferr=%0b required 0", fill_err);
    end
    do_write(4'd3, 8'h5a);
    $display("stray write: ram_we=%0b ferr=%0b", lut_ram_we, fill_err);
    n_checks++;
    if (lut_ram_we !== 1'b0 || fill_err !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_write: we=%0b ferr=%0b required 0 1", lut_ram_we, fill_err);
    end
  endtask

  task automatic test_incomplete_fill();
    enable = 1'b1;
    tick();
    pulse_sof();
    tick();
    pulse_sof();
    n_checks++;
    if (rebuild_start !== 1'b1) begin
      n_fail++;
      $display("FAIL incomplete_start: start=%0b required 1", rebuild_start);
    end
    fill_range(0, 7, 1'b1, "partial");
    do_write(4'd15, 8'hee);
    $display("early last write: ram_we=%0b addr=%0d ferr=%0b busy=%0b",
             lut_ram_we, lut_ram_addr, fill_err, busy);
    n_checks++;
    if (lut_ram_we !== 1'b1 || lut_ram_addr !== 5'd31 || fill_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL incomplete_last: we=%0b addr=%0d ferr=%0b busy=%0b required 1 31 1 0",
               lut_ram_we, lut_ram_addr, fill_err, busy);
    end
    tick();
    pulse_sof();
    n_checks++;
    if (bank_swap !== 1'b0 || rd_bank !== 1'b0 || rebuild_start !== 1'b0) begin
      n_fail++;
      $display("FAIL incomplete_noswap: swap=%0b rd_bank=%0b start=%0b required 0 0 0",
               bank_swap, rd_bank, rebuild_start);
    end
  endtask

  task automatic test_sof_collision();
    enable = 1'b1;
    tick();
    pulse_sof();
    tick();
    pulse_sof();
    fill_range(0, 14, 1'b1, "collide");
    sof = 1'b1;
    do_write(4'd15, 8'h2e);
    sof = 1'b0;
    $display("last write with sof: busy=%0b swap=%0b rd_bank=%0b ferr=%0b",
             busy, bank_swap, rd_bank, fill_err);
    n_checks++;
    if (busy !== 1'b1 || bank_swap !== 1'b0 || rd_bank !== 1'b0 || fill_err !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_pending: busy=%0b swap=%0b rd_bank=%0b ferr=%0b required 1 0 0 0",
               busy, bank_swap, rd_bank, fill_err);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || bank_swap !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_hold: busy=%0b swap=%0b required 1 0", busy, bank_swap);
    end
    pulse_sof();
    $display("sof after collision: swap=%0b rd_bank=%0b", bank_swap, rd_bank);
    n_checks++;
    if (bank_swap !== 1'b1 || rd_bank !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_swap: swap=%0b rd_bank=%0b busy=%0b required 1 1 0",
               bank_swap, rd_bank, busy);
    end
  endtask

  task automatic test_enable_drop_and_reset();
    pulse_sof();
    n_checks++;
    if (rebuild_start !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_start: start=%0b required 1", rebuild_start);
    end
    fill_range(0, 4, 1'b0, "drop");
    enable = 1'b0;
    tick();
    $display("enable dropped: busy=%0b rd_bank=%0b", busy, rd_bank);
    n_checks++;
    if (busy !== 1'b0 || rd_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_idle: busy=%0b rd_bank=%0b required 0 1", busy, rd_bank);
    end
    pulse_sof();
    n_checks++;
    if (rebuild_start !== 1'b0 || busy !== 1'b0 || bank_swap !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_nostart: start=%0b busy=%0b swap=%0b required 0 0 0",
               rebuild_start, busy, bank_swap);
    end
    enable = 1'b1;
    tick();
    pulse_sof();
    tick();
    pulse_sof();
    n_checks++;
    if (rebuild_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reenable_start: start=%0b required 1", rebuild_start);
    end
    fill_range(0, 15, 1'b0, "refill");
    tick();
    n_checks++;
    if (busy !== 1'b1 || rd_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL refill_pending: busy=%0b rd_bank=%0b required 1 1", busy, rd_bank);
    end
    @(negedge clk);
    srst = 1'b1;
    #1;
    $display("async reset in PENDING: rd_bank=%0b busy=%0b", rd_bank, busy);
    n_checks++;
    if (rd_bank !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: rd_bank=%0b busy=%0b required 0 0", rd_bank, busy);
    end
    enable = 1'b0;
    tick(); tick();
    srst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({rebuild_start, lut_ram_we, rd_bank, bank_swap, busy, timeout_err, fill_err} !== 7'b0 ||
        lut_ram_addr !== 5'd0 || lut_ram_din !== 8'd0) begin
      n_fail++;
      $display("FAIL post_reset: flags=%b addr=%0d din=%0h required 0000000 0 0",
               {rebuild_start, lut_ram_we, rd_bank, bank_swap, busy, timeout_err, fill_err},
               lut_ram_addr, lut_ram_din);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_first_rebuild();
    test_second_rebuild();
    test_timeout();
    test_stray_write();
    test_reset();
    test_incomplete_fill();
    test_reset();
    test_sof_collision();
    test_enable_drop_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
